// File: rtl/pico_host.sv
// rtl/pico_host.sv - host sequencer driving a pico processor's switch/LED handshake
// Optional build macro: PICO_HOST_LED_SYNC_EN (2-flop synchroniser on LED before capture)
module pico_host #(
  parameter int SETUP_CYCLES = 2,
  parameter int HOLD_CYCLES  = 128,
  parameter int RST_CYCLES   = 4
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic [7:0] in_data,
  input  logic       in_capture,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       restart,
  output logic [9:0] SW,
  input  logic [7:0] LED,
  output logic [7:0] res_data,
  output logic       res_valid,
  input  logic       res_ready
);

  typedef enum logic [2:0] {PRST, IDLE, SETUP, HOLD, RESULT} state_t;

  localparam logic [7:0] SETUP_LD   = 8'(SETUP_CYCLES);
  localparam logic [7:0] HOLD_LD    = 8'(HOLD_CYCLES);
  localparam logic [7:0] RST_LD     = 8'(RST_CYCLES);
  localparam bit         SKIP_SETUP = (SETUP_CYCLES == 0);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [9:0] sw_q, sw_d;
  logic       cap_q, cap_d;
  logic       in_ready_q, in_ready_d;
  logic       res_valid_q, res_valid_d;
  logic [7:0] res_data_q, res_data_d;
  logic [7:0] led_sample;

`ifdef PICO_HOST_LED_SYNC_EN
  logic [7:0] led_s1_q, led_s2_q;

  // Two-stage synchroniser for the processor's LED bus
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      led_s1_q <= 8'h00;
      led_s2_q <= 8'h00;
    end else begin
      led_s1_q <= LED;
      led_s2_q <= led_s1_q;
    end
  end

  assign led_sample = led_s2_q;
`else
  assign led_sample = LED;
`endif

  // Next-state and registered-output computation; restart overrides everything
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sw_d        = sw_q;
    cap_d       = cap_q;
    in_ready_d  = in_ready_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    if (restart) begin
      state_d     = PRST;
      cnt_d       = RST_LD;
      sw_d        = 10'h000;
      in_ready_d  = 1'b0;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        PRST: begin
          if (cnt_q <= 8'd1) begin
            state_d    = IDLE;
            sw_d[9]    = 1'b1;
            in_ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        IDLE: begin
          if (in_valid && in_ready_q) begin
            sw_d[7:0]  = in_data;
            cap_d      = in_capture;
            in_ready_d = 1'b0;
            if (SKIP_SETUP) begin
              state_d = HOLD;
              sw_d[8] = ~sw_q[8];
              cnt_d   = HOLD_LD;
            end else begin
              state_d = SETUP;
              cnt_d   = SETUP_LD;
            end
          end
        end
        SETUP: begin
          if (cnt_q <= 8'd1) begin
            state_d = HOLD;
            sw_d[8] = ~sw_q[8];
            cnt_d   = HOLD_LD;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        HOLD: begin
          if (cnt_q <= 8'd1) begin
            if (cap_q) begin
              res_data_d  = led_sample;
              res_valid_d = 1'b1;
              state_d     = RESULT;
            end else begin
              state_d    = IDLE;
              in_ready_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
          end
        end
        default: begin
          state_d     = PRST;
          cnt_d       = RST_LD;
          sw_d        = 10'h000;
          in_ready_d  = 1'b0;
          res_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset parks the processor in PRST
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= PRST;
      cnt_q       <= RST_LD;
      sw_q        <= 10'h000;
      cap_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sw_q        <= sw_d;
      cap_q       <= cap_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign SW        = sw_q;
  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_pico_host.sv
// tb/tb_pico_host.sv - self-checking bench for pico_host with a phase-level reference model
module tb_pico_host;

  localparam int SETUP = 2;
  localparam int HOLD  = 128;
  localparam int RSTC  = 4;

  logic       Clock = 1'b0;
  logic       nReset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_capture = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       restart = 1'b0;
  logic [9:0] SW;
  logic [7:0] LED = 8'h00;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_ready = 1'b0;

  int tests_run = 0;
  int failed = 0;
  bit model_sw8 = 1'b0;

  pico_host dut (
    .Clock(Clock), .nReset(nReset), .in_data(in_data), .in_capture(in_capture),
    .in_valid(in_valid), .in_ready(in_ready), .restart(restart), .SW(SW),
    .LED(LED), .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // One complete phase: accept, setup length, hold length, optional result hand-off
  task automatic run_phase(input logic [7:0] data, input bit cap, input logic [7:0] led_old,
                           input logic [7:0] led_new, input bit late, input int rdy_delay);
    int n;
    bit stable;
    logic [7:0] exp_res;
    logic [9:0] exp_sw;
    n = 0;
    while (in_ready !== 1'b1 && n < 300) begin tick; n++; end
    tests_run++;
    if (in_ready !== 1'b1) begin failed++; $display("FAIL phase_ready: in_ready=%b required 1", in_ready); end
    in_data = data; in_capture = cap; in_valid = 1'b1;
    LED = late ? led_old : led_new;
    tick;
    in_valid = 1'b0; in_data = 8'($urandom); in_capture = 1'($urandom);
    tests_run++;
    if (SW[7:0] !== data || in_ready !== 1'b0) begin
      failed++; $display("FAIL accept: SW[7:0]=%h in_ready=%b required %h 0", SW[7:0], in_ready, data);
    end
    model_sw8 = ~model_sw8;
    exp_sw = {1'b1, model_sw8, data};
    n = 0;
    while (SW[8] !== model_sw8 && n < 300) begin tick; n++; end
    tests_run++;
    if (n != SETUP) begin failed++; $display("FAIL setup_len: got %0d cycles required %0d", n, SETUP); end
    tests_run++;
    if (SW !== exp_sw) begin failed++; $display("FAIL sw_hold: SW=%h required %h", SW, exp_sw); end
    n = 0; stable = 1'b1;
    while (!(in_ready === 1'b1 || res_valid === 1'b1) && n < 300) begin
      if (late && n == HOLD - 1) LED = led_new;
      if (SW !== exp_sw) stable = 1'b0;
      tick; n++;
    end
    tests_run++;
    if (n != HOLD || !stable) begin
      failed++; $display("FAIL hold_len: got %0d cycles stable=%0d required %0d stable=1", n, stable, HOLD);
    end
`ifdef PICO_HOST_LED_SYNC_EN
    exp_res = late ? led_old : led_new;
`else
    exp_res = led_new;
`endif
    if (cap) begin
      tests_run++;
      if (res_valid !== 1'b1 || res_data !== exp_res || in_ready !== 1'b0) begin
        failed++; $display("FAIL result: valid=%b data=%h in_ready=%b required 1 %h 0", res_valid, res_data, in_ready, exp_res);
      end
      stable = 1'b1;
      for (int i = 0; i < rdy_delay; i++) begin
        tick;
        if (res_valid !== 1'b1 || res_data !== exp_res || in_ready !== 1'b0) stable = 1'b0;
      end
      tests_run++;
      if (!stable) begin failed++; $display("FAIL result_stall: result not stable over %0d cycles, required stable", rdy_delay); end
      res_ready = 1'b1;
      tick;
      res_ready = 1'b0;
      tests_run++;
      if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
        failed++; $display("FAIL consume: valid=%b in_ready=%b required 0 1", res_valid, in_ready);
      end
    end else begin
      tests_run++;
      if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
        failed++; $display("FAIL no_capture_exit: valid=%b in_ready=%b required 0 1", res_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset;
    int n;
    #2;
    tests_run++;
    if (SW !== 10'h000 || in_ready !== 1'b0 || res_valid !== 1'b0 || res_data !== 8'h00) begin
      failed++; $display("FAIL reset_values: SW=%h rdy=%b valid=%b data=%h required 000 0 0 00", SW, in_ready, res_valid, res_data);
    end
    tick;
    nReset = 1'b1; model_sw8 = 1'b0;
    n = 0;
    while (SW[9] !== 1'b1 && n < 50) begin
      tick; n++;
    end
    tests_run++;
    if (n != RSTC) begin failed++; $display("FAIL prst_len: got %0d cycles required %0d", n, RSTC); end
    tests_run++;
    if (SW !== 10'h200 || in_ready !== 1'b1) begin
      failed++; $display("FAIL post_reset: SW=%h in_ready=%b required 200 1", SW, in_ready);
    end
  endtask

  task automatic test_single_phase;
    run_phase(8'h28, 1'b0, 8'h00, 8'h00, 1'b0, 0);
  endtask

  task automatic test_sequence;
    logic [7:0] datas [6];
    bit         seq   [6];
    int n;
    datas = '{8'h28, 8'h00, 8'h14, 8'h00, 8'h00, 8'h00};
    seq   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    restart = 1'b1; tick; restart = 1'b0; model_sw8 = 1'b0;
    n = 0;
    while (SW[9] !== 1'b1 && n < 50) begin tick; n++; end
    tests_run++;
    if (n != RSTC) begin failed++; $display("FAIL seq_restart_len: got %0d required %0d", n, RSTC); end
    for (int i = 0; i < 6; i++) begin
      run_phase(datas[i], (i == 3 || i == 4), 8'h00, (i == 3) ? 8'h3C : 8'hF6, 1'b0, 0);
      tests_run++;
      if (SW[8] !== seq[i]) begin failed++; $display("FAIL seq_sw8[%0d]: SW[8]=%b required %b", i, SW[8], seq[i]); end
    end
  endtask

  task automatic test_result_stall;
    run_phase(8'($urandom), 1'b1, 8'h00, 8'($urandom), 1'b0, 50);
  endtask

  task automatic test_restart_mid_hold;
    int n;
    bit sw_zero;
    n = 0;
    while (in_ready !== 1'b1 && n < 300) begin tick; n++; end
    in_data = 8'h77; in_capture = 1'b1; in_valid = 1'b1; LED = 8'h99;
    tick;
    in_valid = 1'b0;
    n = 0;
    while (SW[8] === model_sw8 && n < 300) begin tick; n++; end
    for (int i = 0; i < 10; i++) tick;
    restart = 1'b1; in_valid = 1'b1; in_data = 8'hAA; in_capture = 1'b1;
    tick;
    restart = 1'b0;
    in_valid = 1'b0;
    model_sw8 = 1'b0;
    tests_run++;
    if (SW !== 10'h000 || in_ready !== 1'b0 || res_valid !== 1'b0) begin
      failed++; $display("FAIL restart_entry: SW=%h rdy=%b valid=%b required 000 0 0", SW, in_ready, res_valid);
    end
    n = 0; sw_zero = 1'b1;
    while (SW[9] !== 1'b1 && n < 50) begin
      if (SW !== 10'h000 || res_valid !== 1'b0) sw_zero = 1'b0;
      tick; n++;
    end
    tests_run++;
    if (n != RSTC || !sw_zero) begin
      failed++; $display("FAIL restart_prst: got %0d cycles zero=%0d required %0d zero=1", n, sw_zero, RSTC);
    end
    tests_run++;
    if (SW !== 10'h200 || res_valid !== 1'b0) begin
      failed++; $display("FAIL restart_exit: SW=%h valid=%b required 200 0", SW, res_valid);
    end
    run_phase(8'($urandom), 1'b0, 8'h00, 8'h00, 1'b0, 0);
    tests_run++;
    if (SW[8] !== 1'b1) begin failed++; $display("FAIL restart_next_sw8: SW[8]=%b required 1", SW[8]); end
  endtask

  task automatic test_reset_mid_phase;
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 300) begin tick; n++; end
    in_data = 8'h3E; in_capture = 1'b1; in_valid = 1'b1; LED = 8'h55;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick;
    #2 nReset = 1'b0;
    #1;
    tests_run++;
    if (SW !== 10'h000 || in_ready !== 1'b0 || res_valid !== 1'b0 || res_data !== 8'h00) begin
      failed++; $display("FAIL async_reset: SW=%h rdy=%b valid=%b data=%h required 000 0 0 00", SW, in_ready, res_valid, res_data);
    end
    tick; tick;
    nReset = 1'b1; model_sw8 = 1'b0;
    n = 0;
    while (SW[9] !== 1'b1 && n < 50) begin tick; n++; end
    tests_run++;
    if (n != RSTC || res_valid !== 1'b0) begin
      failed++; $display("FAIL reset_abandon: got %0d cycles valid=%b required %0d 0", n, res_valid, RSTC);
    end
  endtask

  task automatic test_led_timing;
    run_phase(8'h5C, 1'b1, 8'h5A, 8'hA5, 1'b1, 0);
  endtask

  task automatic test_back_to_back;
    run_phase(8'h11, 1'b1, 8'h00, 8'hC3, 1'b0, 0);
    run_phase(8'h22, 1'b0, 8'h00, 8'h00, 1'b0, 0);
    run_phase(8'h33, 1'b1, 8'h00, 8'h3C, 1'b0, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      run_phase(8'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                int'($urandom_range(0, 5)));
    end
  endtask

  initial begin
    test_reset;
    test_single_phase;
    test_sequence;
    test_result_stall;
    test_restart_mid_hold;
    test_reset_mid_phase;
    test_led_timing;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/pico_host.md
PICO_HOST -- requirements
Module: pico_host

Interface
REQ-001 Parameter SETUP_CYCLES, default 2, cycles SW[7:0] is stable before SW[8] toggles (0..255).
REQ-002 Parameter HOLD_CYCLES, default 128, cycles SW[8] is held at its new level before the phase completes (1..255).
REQ-003 Parameter RST_CYCLES, default 4, cycles SW[9] is held low after reset or restart (1..255).
REQ-004 Clock  input  1  single clock, all state rising-edge.
REQ-005 nReset  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  8  operand byte for the next phase.
REQ-007 in_capture  input  1  phase samples LED at completion.
REQ-008 in_valid  input  1  phase request.
REQ-009 in_ready  output  1  phase request accepted when in_valid and in_ready are both high.
REQ-010 restart  input  1  synchronous abort and processor re-reset.
REQ-011 SW  output  10  drives the processor switches: [9] processor reset (active-low), [8] handshake level, [7:0] data.
REQ-012 LED  input  8  processor accumulator output.
REQ-013 res_data  output  8  captured LED value.
REQ-014 res_valid  output  1  res_data valid; held until res_ready.
REQ-015 res_ready  input  1  result consumer ready.

Function
REQ-016 States: PRST, IDLE, SETUP, HOLD, RESULT.
REQ-017 PRST: SW[9]=0, SW[8]=0, SW[7:0]=0, in_ready=0; stays RST_CYCLES cycles, then goes to IDLE with SW[9]=1.
REQ-018 IDLE: in_ready=1; on accept, the next edge latches SW[7:0]<=in_data and the capture flag, and enters SETUP with a counter of SETUP_CYCLES (HOLD directly if SETUP_CYCLES=0).
REQ-019 SETUP: SW[8] unchanged, counter decrements each cycle; when it reaches zero, SW[8] inverts on the same edge and the state becomes HOLD with counter=HOLD_CYCLES.
REQ-020 HOLD: SW[7:0] and SW[8] stable; on the edge ending the HOLD_CYCLES-th cycle, if capture then res_data<=sampled LED, res_valid<=1, state RESULT, else IDLE.
REQ-021 RESULT: res_valid=1, res_data stable, in_ready=0; on res_valid&&res_ready go to IDLE with res_valid<=0.
REQ-022 SW[8] alternates each phase, starting at 1 for the first phase after PRST; there is no other way to change SW[8].
REQ-023 SW[7:0] holds the last accepted in_data until the next accept or restart.
REQ-024 restart has priority over every state and over a simultaneous in_valid: next edge enters PRST and clears res_valid; an in-flight phase is discarded.
REQ-025 Back-to-back: an accept in IDLE is permitted on the cycle after RESULT or HOLD exits; there are no idle bubbles beyond that single IDLE cycle.
REQ-026 Counters are 8-bit; no wrap occurs within legal parameter ranges.

Reset
REQ-027 nReset low asynchronously forces PRST, SW=10'h000, res_valid=0, res_data=0, in_ready=0, and the counter loaded to RST_CYCLES.
REQ-028 After nReset deasserts, PRST runs its full RST_CYCLES count.
REQ-029 Reset mid-phase abandons the phase without producing any result.

Configuration
REQ-030 With PICO_HOST_LED_SYNC_EN defined, LED passes through a 2-flop synchroniser and the value captured is the synchroniser output.
REQ-031 Without PICO_HOST_LED_SYNC_EN, LED is sampled directly at the capture edge.
REQ-032 Phase timing is identical in both builds.

Verification
REQ-033 Reset release, defaults: SW[9]=0 for 4 cycles, then SW=10'h200 and in_ready=1.
REQ-034 Accept in_data=8'h28, capture=0: SW[7:0]=8'h28 after 1 cycle; SW[8] rises 2 cycles later and holds 128 cycles; in_ready returns high; no res_valid.
REQ-035 Six phases with data 0x28, 0x00, 0x14, 0x00, 0x00, 0x00 and capture only on phases 4 and 5, with the LED model driving 8'h3C and then 8'hF6: results are 0x3C and 0xF6; SW[8] sequence is 1,0,1,0,1,0.
REQ-036 Capture with res_ready held low for 50 cycles: res_valid and res_data stay stable and in_ready=0; the result is consumed on the first res_ready cycle.
REQ-037 restart asserted mid-HOLD together with in_valid: PRST entered, SW=0 for 4 cycles, no result, request not accepted, and the next phase drives SW[8]=1.
REQ-038 PICO_HOST_LED_SYNC_EN build with LED changing 1 cycle before the capture edge: the captured value is the old LED value; without the macro it is the new value.
